// File: rtl/sum_res_norm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sum_res_norm_pkg
//  Purpose  : Shared widths, constants and FSM state type for the
//             post-addition normaliser/rounder (sum_res_norm).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package sum_res_norm_pkg;

  localparam int MANT_W = 8;
  localparam int SUM_W  = 12;
  localparam int EXP_W  = 8;

  localparam logic [EXP_W-1:0]  EXP_MAX  = 8'hFF;
  localparam logic [MANT_W-1:0] SAT_VAL  = 8'hFF;
  // Mantissa after a rounding carry-out: hidden bit set, fraction clear.
  localparam logic [MANT_W-1:0] MANT_ONE = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sum_res_norm_rnd.sv
`default_nettype none
// ============================================================================
//  Module   : sum_res_rnd
//  Purpose  : Combinational rounding-increment decision and mantissa
//             overflow detect for the normalised sum.
//  Macro    : SUM_RES_ROUND_EN - defined: round-to-nearest-even;
//                                 undefined: truncate (G/R/S discarded).
//  Ports    : sum_i[10:0]    normalised sum, [10:3]=mantissa, [2:0]=G,R,S
//             mant_o[7:0]    rounded mantissa (8'h80 on carry-out)
//             mant_ovf_o     rounding carried out of the mantissa
//  Revision : 1.0 - initial release
// ============================================================================
module sum_res_rnd
  import sum_res_norm_pkg::*;
(
  input  logic [SUM_W-2:0]  sum_i,
  output logic [MANT_W-1:0] mant_o,
  output logic              mant_ovf_o
);

  logic [MANT_W-1:0] w_mant;
  logic              w_inc;

  assign w_mant = sum_i[SUM_W-2:3];

`ifdef SUM_RES_ROUND_EN
  // Round up above half, or exactly half when the mantissa is odd.
  assign w_inc = sum_i[2] & (sum_i[1] | sum_i[0] | w_mant[0]);
`else
  logic w_unused_grs;
  assign w_unused_grs = ^sum_i[2:0];
  assign w_inc        = 1'b0;
`endif

  assign mant_ovf_o = w_inc & (w_mant == SAT_VAL);
  assign mant_o     = mant_ovf_o ? MANT_ONE : (w_mant + {{(MANT_W-1){1'b0}}, w_inc});

endmodule
`default_nettype wire

// File: rtl/sum_res_norm.sv
`default_nettype none
// ============================================================================
//  Module   : sum_res_norm
//  Purpose  : Iterative post-addition normaliser and rounder. One shift per
//             cycle, valid/ready handshake on input and output.
//  Macro    : SUM_RES_ROUND_EN (rounding mode, see sum_res_rnd)
//  Ports    : clk_i, rst_i          clock, sync active-high reset
//             valid_i/ready_o       input handshake (ready only in IDLE)
//             sum_i[11:0]           {carry, mant[7:0], G, R, S}
//             exp_i[7:0]            exponent before normalisation
//             valid_o/ready_i       output handshake
//             mant_o, exp_o         normalised result
//             ovf_o, unf_o, zero_o  mutually exclusive status flags
//  Revision : 1.0 - initial release
// ============================================================================
module sum_res_norm
  import sum_res_norm_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [SUM_W-1:0]  sum_i,
  input  logic [EXP_W-1:0]  exp_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [MANT_W-1:0] mant_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic              ovf_o,
  output logic              unf_o,
  output logic              zero_o
);

  state_e            state_q, state_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  rexp_q, rexp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              zero_q, zero_d;

  logic [MANT_W-1:0] w_rnd_mant;
  logic              w_rnd_ovf;

  // NORM-stage decode, evaluated top-down by priority.
  logic w_is_zero, w_carry, w_norm_ok, w_exp_zero, w_exp_max;
  assign w_is_zero  = (sum_q == '0);
  assign w_carry    = sum_q[SUM_W-1];
  assign w_norm_ok  = sum_q[SUM_W-2];
  assign w_exp_zero = (exp_q == '0);
  assign w_exp_max  = (exp_q == EXP_MAX);

  sum_res_rnd u_rnd (
    .sum_i      (sum_q[SUM_W-2:0]),
    .mant_o     (w_rnd_mant),
    .mant_ovf_o (w_rnd_ovf)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (valid_i) state_d = ST_NORM;
      ST_NORM: begin
        if (w_is_zero)                  state_d = ST_DONE;
        else if (w_carry && w_exp_max)  state_d = ST_DONE;
        else if (w_carry)               state_d = ST_NORM;
        else if (w_norm_ok)             state_d = ST_ROUND;
        else if (w_exp_zero)            state_d = ST_DONE;
        else                            state_d = ST_NORM;
      end
      ST_ROUND: state_d = ST_DONE;
      ST_DONE:  if (ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; ready is masked while reset is held.
  always_comb begin
    ready_o = (state_q == ST_IDLE) && !rst_i;
    valid_o = (state_q == ST_DONE);
  end

  // Datapath next-state
  always_comb begin
    sum_d  = sum_q;
    exp_d  = exp_q;
    mant_d = mant_q;
    rexp_d = rexp_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    zero_d = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          sum_d  = sum_i;
          exp_d  = exp_i;
          mant_d = '0;
          rexp_d = '0;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          zero_d = 1'b0;
        end
      end
      ST_NORM: begin
        if (w_is_zero) begin
          mant_d = '0;
          rexp_d = '0;
          zero_d = 1'b1;
        end else if (w_carry && w_exp_max) begin
          mant_d = SAT_VAL;
          rexp_d = SAT_VAL;
          ovf_d  = 1'b1;
        end else if (w_carry) begin
          // Right shift; the dropped bit is folded into sticky.
          sum_d = {1'b0, sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
          exp_d = exp_q + 8'd1;
        end else if (w_norm_ok) begin
          sum_d = sum_q;
        end else if (w_exp_zero) begin
          mant_d = '0;
          rexp_d = '0;
          unf_d  = 1'b1;
        end else begin
          sum_d = sum_q << 1;
          exp_d = exp_q - 8'd1;
        end
      end
      ST_ROUND: begin
        if (w_rnd_ovf && w_exp_max) begin
          mant_d = SAT_VAL;
          rexp_d = SAT_VAL;
          ovf_d  = 1'b1;
        end else begin
          mant_d = w_rnd_mant;
          rexp_d = exp_q + {{(EXP_W-1){1'b0}}, w_rnd_ovf};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q  <= '0;
      exp_q  <= '0;
      mant_q <= '0;
      rexp_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      exp_q  <= exp_d;
      mant_q <= mant_d;
      rexp_q <= rexp_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      zero_q <= zero_d;
    end
  end

  assign mant_o = mant_q;
  assign exp_o  = rexp_q;
  assign ovf_o  = ovf_q;
  assign unf_o  = unf_q;
  assign zero_o = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_res_norm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sum_res_norm
//  Purpose  : Scoreboard bench for sum_res_norm; a reference model computes
//             each expected result and latency from the normalisation rules.
//  Macro    : SUM_RES_ROUND_EN selects the rounding mode in the model too.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sum_res_norm;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [11:0] sum_i;
  logic [7:0]  exp_i;
  logic        valid_o;
  logic        ready_i;
  logic [7:0]  mant_o;
  logic [7:0]  exp_o;
  logic        ovf_o, unf_o, zero_o;

  sum_res_norm dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .sum_i   (sum_i),
    .exp_i   (exp_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .mant_o  (mant_o),
    .exp_o   (exp_o),
    .ovf_o   (ovf_o),
    .unf_o   (unf_o),
    .zero_o  (zero_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  mant;
    logic [7:0]  ex;
    bit          ovf;
    bit          unf;
    bit          zero;
    int          lat;
    int unsigned acc;
  } res_t;

  res_t q[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   hold_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: locate the leading one, shift into place, then round.
  function automatic res_t model(input logic [11:0] s, input logic [7:0] e);
    res_t        r;
    logic [11:0] v;
    int          ex, p, k;
    logic [7:0]  m;
    bit          inc;
    r.mant = 8'h00; r.ex = 8'h00; r.ovf = 0; r.unf = 0; r.zero = 0; r.lat = 0; r.acc = 0;
    ex = e;
    p  = -1;
    for (int i = 0; i < 12; i++) if (s[i]) p = i;
    if (p < 0) begin
      r.zero = 1; r.lat = 2;
      return r;
    end
    if (p == 11) begin
      if (ex == 255) begin
        r.ovf = 1; r.mant = 8'hFF; r.ex = 8'hFF; r.lat = 2;
        return r;
      end
      v = (s >> 1) | {11'd0, s[0]};
      ex = ex + 1;
      r.lat = 4;
    end else begin
      k = 10 - p;
      if (ex < k) begin
        r.unf = 1; r.lat = 2 + ex;
        return r;
      end
      v = s << k;
      ex = ex - k;
      r.lat = 3 + k;
    end
    m = v[10:3];
`ifdef SUM_RES_ROUND_EN
    inc = v[2] && (v[1] || v[0] || m[0]);
`else
    inc = 0;
`endif
    if (inc) begin
      if (m == 8'hFF) begin
        m = 8'h80;
        if (ex == 255) begin
          r.ovf = 1; r.mant = 8'hFF; r.ex = 8'hFF;
          return r;
        end
        ex = ex + 1;
      end else begin
        m = m + 8'd1;
      end
    end
    r.mant = m;
    r.ex   = 8'(ex);
    return r;
  endfunction

  // Issue one word (called at a negedge); returns 1 ns after the accept edge.
  task automatic send(input logic [11:0] s, input logic [7:0] e, input bit track);
    int   t;
    res_t r;
    t = 0;
    while (!ready_o && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    if (!ready_o) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    valid_i = 1'b1;
    sum_i   = s;
    exp_i   = e;
    @(posedge clk_i);
    #1;
    r     = model(s, e);
    r.acc = cyc;
    if (track) q.push_back(r);
    valid_i = 1'b0;
    sum_i   = 12'($urandom);
    exp_i   = 8'($urandom);
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    res_t        exp_r;
    bit          in_done;
    logic [11:0] snap;
    in_done = 0;
    ready_i = 1'b0;
    snap    = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        in_done = 0;
        ready_i = 1'b0;
      end else begin
        if (valid_o) begin
          chk("ready_in_done", ready_o, 0);
          if (!in_done) begin
            in_done = 1;
            if (q.size() == 0) begin
              chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
              exp_r = q.pop_front();
              chk("mant", mant_o, exp_r.mant);
              chk("exp", exp_o, exp_r.ex);
              chk("ovf", ovf_o, exp_r.ovf);
              chk("unf", unf_o, exp_r.unf);
              chk("zero", zero_o, exp_r.zero);
              chk("latency", cyc - exp_r.acc + 1, exp_r.lat);
            end
            snap = {mant_o, ovf_o, unf_o, zero_o, 1'b0};
          end else begin
            chk("hold_mant_flags", {mant_o, ovf_o, unf_o, zero_o, 1'b0}, snap);
          end
          if (hold_n > 0) begin
            ready_i = 1'b0;
            hold_n--;
          end else begin
            ready_i = ($urandom % 4) != 0;
          end
        end else begin
          in_done = 0;
          ready_i = ($urandom % 2) != 0;
        end
      end
    end
  end

  initial begin : stim
    int          t, p, sel;
    logic [11:0] s;
    logic [7:0]  e;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    sum_i   = '0;
    exp_i   = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_ready", ready_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_outs", {mant_o, exp_o, ovf_o, unf_o, zero_o}, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("ready_after_rst", ready_o, 1);

    send(12'h400, 8'd127, 1); @(negedge clk_i);
    send(12'h800, 8'd10,  1); @(negedge clk_i);
    send(12'h800, 8'd255, 1); @(negedge clk_i);
    send(12'h020, 8'd20,  1); @(negedge clk_i);
    send(12'h200, 8'd0,   1); @(negedge clk_i);
    send(12'h7FC, 8'd50,  1); @(negedge clk_i);
    send(12'h404, 8'd60,  1); @(negedge clk_i);
    send(12'h7FC, 8'd255, 1); @(negedge clk_i);
    send(12'h001, 8'd40,  1); @(negedge clk_i);

    // Zero word held in DONE; inputs offered meanwhile must be ignored.
    send(12'h000, 8'd33, 1);
    hold_n = 5;
    t = 0;
    @(negedge clk_i);
    while (!valid_o && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    chk("zero_valid_seen", valid_o, 1);
    valid_i = 1'b1;
    sum_i   = 12'h400;
    exp_i   = 8'd1;
    repeat (3) begin
      chk("ready_low_done", ready_o, 0);
      @(negedge clk_i);
    end
    valid_i = 1'b0;
    @(negedge clk_i);

    // Reset in the middle of a 10-shift word: nothing may be emitted.
    send(12'h001, 8'd20, 0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_ready", ready_o, 0);
    chk("midrst_outs", {mant_o, exp_o, ovf_o, unf_o, zero_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    send(12'h001, 8'd20, 1); @(negedge clk_i);

    for (int n = 0; n < 300; n++) begin
      p = $urandom_range(0, 12);
      if (p == 12) s = 12'h000;
      else         s = 12'((1 << p) | ($urandom & ((1 << p) - 1)));
      sel = $urandom % 8;
      case (sel)
        0:       e = 8'd0;
        1:       e = 8'd255;
        2:       e = 8'($urandom % 12);
        3:       e = 8'd254;
        default: e = 8'($urandom);
      endcase
      send(s, e, 1);
      @(negedge clk_i);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    t = 0;
    while ((q.size() != 0 || valid_o) && t < 500) begin
      @(negedge clk_i);
      t++;
    end
    chk("drain_queue", q.size(), 0);
    repeat (3) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sum_res_norm.md
# sum_res_norm

Post-addition normaliser and rounder for the FP add/sub datapath. It takes the raw 12-bit mantissa sum, the pre-normalisation exponent and the three guard bits left by pre-alignment. It produces a normalised 8-bit mantissa (hidden bit included), an adjusted exponent and status flags. It runs as an iterative FSM, one shift per cycle, between the mantissa adder and the result register, and uses valid/ready handshakes on both sides.

## Interface
- Parameters: none; all widths come from the shared package.
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- valid_i  in  1  input word valid
- ready_o  out  1  block can accept; high only in IDLE
- sum_i  in  12  [11]=carry, [10:3]=mantissa (hidden bit at [10]), [2]=G, [1]=R, [0]=S
- exp_i  in  8  exponent before normalisation
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result
- mant_o  out  8  normalised mantissa, [7]=hidden bit
- exp_o  out  8  normalised exponent
- ovf_o  out  1  exponent overflow; result saturated
- unf_o  out  1  exponent underflow; result forced to zero
- zero_o  out  1  exact-zero sum

## Operation
- **States:** IDLE, NORM, ROUND, DONE.
- **IDLE:** ready_o=1. When valid_i is high, register sum_i and exp_i, clear flags, and go to NORM.
- **NORM:** one action per cycle, priority top-down:
  - sum==0: set mant=0, exp=0, zero_o=1, go to DONE (ROUND skipped).
  - sum[11]=1 and exp==255: overflow, go to DONE.
  - sum[11]=1: sum={1'b0, sum[11:2], sum[1]|sum[0]}, exp+1. The sticky bit absorbs the dropped bit.
  - sum[10]=1: go to ROUND.
  - exp==0: underflow. Set unf_o=1, mant=0, exp=0, go to DONE.
  - Otherwise: sum<<=1, exp-1.
- **ROUND:** m=sum[10:3]. Rounding rule is under Configuration.
  - If rounding increments m==8'hFF: m=8'h80, exp+1.
  - If that exp+1 wraps past 255: overflow.
- **Overflow:** mant_o=8'hFF, exp_o=8'hFF, ovf_o=1.
- **DONE:** valid_o=1. mant_o, exp_o and flags are stable while ready_i is low. When valid_i... not applicable; when ready_i is high, go to IDLE and drop valid_o.
- The flags are mutually exclusive.
- Inputs arriving outside IDLE are ignored; ready_o=0 there.

## Timing
- Reset: all outputs 0 (ready_o=0 during reset). IDLE with ready_o=1 on the first cycle after rst_i falls.
- Accept edge is cycle 0. valid_o rises at:
  - cycle 3 when sum_i[11:10]==2'b01.
  - +1 for a carry shift.
  - +k for k left shifts (max 10, at sum_i=12'h001, giving cycle 13).
- Zero and underflow-with-no-shift results: valid_o at cycle 2.
- Throughput: at most one result per (latency+1) cycles. The DONE→IDLE handoff costs one cycle with ready_o low.
- rst_i mid-operation abandons the word; nothing is emitted.

## Configuration
- SUM_RES_ROUND_EN defined: round-to-nearest-even. Increment when G & (R | S | m[0]).
- SUM_RES_ROUND_EN undefined: truncate. m=sum[10:3], G/R/S discarded, ROUND still takes one cycle. The latency is identical in both builds.

## Structure
- Shared package holds:
  - widths: MANT_W=8, SUM_W=12, EXP_W=8, EXP_MAX=8'hFF
  - state enum {IDLE, NORM, ROUND, DONE}
  - saturation constant 8'hFF
- One natural sub-module: sum_res_rnd, the combinational rounding-increment decision plus mantissa-overflow detect. It holds the SUM_RES_ROUND_EN switch.

## Test plan
- sum_i=12'h400, exp_i=127 → mant_o=8'h80, exp_o=127, no flags, valid_o at cycle 3.
- sum_i=12'h800, exp_i=10 → mant_o=8'h80, exp_o=11 at cycle 4. Same sum_i with exp_i=255 → ovf_o=1, mant_o=exp_o=8'hFF.
- sum_i=12'h020, exp_i=20 → 5 left shifts, mant_o=8'h80, exp_o=15 at cycle 8. sum_i=12'h200, exp_i=0 → unf_o=1, zeros.
- sum_i=12'h7FC, exp_i=50 → with SUM_RES_ROUND_EN: mant_o=8'h80, exp_o=51. Without it: mant_o=8'hFF, exp_o=50. sum_i=12'h404 (tie, even) → mant_o=8'h80 in both builds.
- sum_i=12'h000 → zero_o=1 at cycle 2. Hold ready_i=0 for 5 cycles → outputs stable, ready_o=0, new valid_i ignored.
- Assert rst_i in NORM during a 10-shift word → all outputs 0 next cycle, no valid_o. The next word processes correctly.
